keypad_scanner: RTL and testbench
=================================

// Module: keypad_scanner
// PURPOSE
//  Input-side counterpart to the 7-seg anode multiplexer: strobes the 4 columns of a 4x4 membrane
//  keypad (active-low, one column at a time) and reads the 4 row lines (active-low, board pull-ups).
//  Synchronises and debounces the rows, then emits a one-cycle key_valid strobe with a 4-bit key code.
//  Sits between the keypad Pmod pins and the FIFO write port / display data path.
// PARAMETERS
//  SCAN_DIV      100_000  clk cycles each column is driven (1 ms @ 100 MHz); min 4
//  DEBOUNCE_CNT  20       consecutive matching samples (one per SCAN_DIV slot) to accept press/release
//  REPEAT_DLY    500      slots held before first auto-repeat (KEYPAD_REPEAT_EN only)
//  REPEAT_RATE   100      slots between subsequent repeats (KEYPAD_REPEAT_EN only)
// PORTS
//  clk        in   1  system clock
//  reset_n    in   1  asynchronous active-low reset
//  row_n      in   4  keypad rows, active-low, asynchronous to clk
//  col_n      out  4  column drive, active-low, exactly one bit low after reset
//  key_code   out  4  {row_idx[1:0], col_idx[1:0]} of accepted key; stable until the next accept
//  key_valid  out  1  one-cycle strobe on accepted press (and on each repeat when enabled)
//  key_held   out  1  high from accept until release is debounced
// BEHAVIOUR
//  Reset (async assert, sync release): col_n=4'b1110, key_code=0, key_valid=0, key_held=0, state=SCAN,
//   all counters 0. Reset mid-press discards the press; no strobe on release.
//  row_n passes a 2-flop synchroniser; "sample" = synchronised rows in the last cycle of each slot.
//  slot counter 0..SCAN_DIV-1, wraps; column index advances 0->1->2->3->0 only in SCAN.
//  FSM:
//   SCAN:     sample all-ones -> advance column. Any row low -> latch col/row, deb_cnt=1, go DEBOUNCE
//             (column frozen). Several rows low in one column: lowest row index wins.
//   DEBOUNCE: sample equals latched row pattern -> deb_cnt++; reaching DEBOUNCE_CNT -> PRESSED,
//             key_code updated, key_valid=1 for the entering cycle, key_held=1.
//             Sample differs (bounce/other key) -> back to SCAN, same column, no strobe.
//   PRESSED:  latched row still low -> stay. Latched row high -> deb_cnt=1, go RELEASE.
//   RELEASE:  latched row high for DEBOUNCE_CNT samples -> key_held=0, advance column, SCAN.
//             Latched row low again -> back to PRESSED, no new strobe.
//  Other keys pressed while in PRESSED/RELEASE are ignored (no n-key rollover).
//  Latency: press stable at pins -> key_valid within 2 clk + DEBOUNCE_CNT*SCAN_DIV*(<=4 slots scan).
//  deb_cnt saturates; width $clog2(DEBOUNCE_CNT+1). Slot counter width $clog2(SCAN_DIV).
// CONFIGURATION
//  `define KEYPAD_REPEAT_EN: in PRESSED, slot counter rep_cnt counts held slots; key_valid re-pulses
//   (same key_code) after REPEAT_DLY slots, then every REPEAT_RATE slots; rep_cnt clears on PRESSED entry.
//  Without it: exactly one key_valid per debounced press; REPEAT_* parameters unused.
// STRUCTURE
//  keypad_pkg: FSM state encoding (SCAN, DEBOUNCE, PRESSED, RELEASE), COLS=4/ROWS=4, KEY_NONE row pattern.
//  One sub-module: keypad_sync (2-flop row synchroniser, parameter WIDTH, reset value all-ones).
//  Top holds slot counter, column rotator, FSM, debounce and repeat counters.
// TESTING  (SCAN_DIV=4, DEBOUNCE_CNT=3, REPEAT_DLY=5, REPEAT_RATE=2)
//  1 Reset, no keys -> col_n cycles 1110,1101,1011,0111 every 4 clk; key_valid never asserts.
//  2 Clean press row2/col1 held -> single key_valid, key_code=4'b1001, key_held=1 until released
//    + 3 slots; col_n frozen at 1101 throughout.
//  3 Bounce: row toggles each slot for 2 slots then stable -> exactly one key_valid, no glitch strobe.
//  4 Rows 1 and 3 low together on col0 -> key_code=4'b0100; second key on col2 during hold ignored.
//  5 reset_n pulled low mid-DEBOUNCE and mid-PRESSED -> outputs to reset values immediately, no strobe.
//  6 KEYPAD_REPEAT_EN, key held 12 slots -> strobes at accept, +5, +7, +9, +11 slots; none without macro.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x4 keypad scanner: FSM encoding, matrix size
// and the all-released row pattern.
package keypad_pkg;

    localparam int COLS = 4;
    localparam int ROWS = 4;

    localparam logic [ROWS-1:0] KEY_NONE = '1;

    typedef enum logic [1:0] {
        ST_SCAN,
        ST_DEBOUNCE,
        ST_PRESSED,
        ST_RELEASE
    } state_t;

    // Lowest-numbered active-low row wins when several rows are pulled down.
    function automatic logic [1:0] lowest_low(input logic [ROWS-1:0] rows);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = ROWS - 1; i >= 0; i--) begin
            if (!rows[2'(i)]) begin
                idx = 2'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/keypad_sync.sv
// Two-flop synchroniser for the asynchronous keypad row lines; idles at
// all-ones so a released keypad reads as "no key" straight out of reset.
module keypad_sync #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_reg;
    logic [WIDTH-1:0] sync_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta_reg <= '1;
            sync_reg <= '1;
        end else begin
            meta_reg <= d;
            sync_reg <= meta_reg;
        end
    end

    assign q = sync_reg;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 membrane keypad scanner: column strobe, row debounce, one-cycle key strobe.
// Define KEYPAD_REPEAT_EN to re-pulse key_valid while a key stays held.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV     = 100_000,
    parameter int DEBOUNCE_CNT = 20,
    parameter int REPEAT_DLY   = 500,
    parameter int REPEAT_RATE  = 100
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] row_n,
    output logic [3:0] col_n,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int SLOT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DEB_W  = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [SLOT_W-1:0] SLOT_LAST  = SLOT_W'(SCAN_DIV - 1);
    localparam logic [DEB_W-1:0]  DEB_TARGET = DEB_W'(DEBOUNCE_CNT);

    // The synchroniser needs two cycles to settle after a column change.
    if (SCAN_DIV < 4 || DEBOUNCE_CNT < 1 || REPEAT_RATE < 1 || REPEAT_RATE > REPEAT_DLY) begin : g_bad_params
        $error("keypad_scanner: unsupported parameter combination");
    end

    logic [ROWS-1:0]   row_sync;
    logic [SLOT_W-1:0] slot_reg;
    logic              slot_end;
    state_t            state_reg, state_next;
    logic [1:0]        col_reg, col_next;
    logic [1:0]        row_reg, row_next;
    logic [ROWS-1:0]   pat_reg, pat_next;
    logic [DEB_W-1:0]  deb_reg, deb_next, deb_inc;
    logic [3:0]        code_reg, code_next;
    logic              valid_reg, valid_next;
    logic              held_reg, held_next;
    logic              row_released;

`ifdef KEYPAD_REPEAT_EN
    localparam int REP_W = $clog2(REPEAT_DLY + 1);
    localparam logic [REP_W-1:0] REP_LAST   = REP_W'(REPEAT_DLY);
    localparam logic [REP_W-1:0] REP_RELOAD = REP_W'(REPEAT_DLY - REPEAT_RATE);
    logic [REP_W-1:0] rep_reg, rep_next, rep_inc;
`endif

    keypad_sync #(.WIDTH(ROWS)) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (row_n),
        .q       (row_sync)
    );

    assign slot_end     = (slot_reg == SLOT_LAST);
    assign deb_inc      = (deb_reg == DEB_TARGET) ? deb_reg : deb_reg + 1'b1;
    assign row_released = row_sync[row_reg];

    for (genvar gi = 0; gi < COLS; gi++) begin : g_col
        assign col_n[gi] = (col_reg != 2'(gi));
    end

    assign key_code  = code_reg;
    assign key_valid = valid_reg;
    assign key_held  = held_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            slot_reg  <= '0;
            state_reg <= ST_SCAN;
            col_reg   <= '0;
            row_reg   <= '0;
            pat_reg   <= KEY_NONE;
            deb_reg   <= '0;
            code_reg  <= '0;
            valid_reg <= 1'b0;
            held_reg  <= 1'b0;
        end else begin
            slot_reg  <= slot_end ? '0 : slot_reg + 1'b1;
            state_reg <= state_next;
            col_reg   <= col_next;
            row_reg   <= row_next;
            pat_reg   <= pat_next;
            deb_reg   <= deb_next;
            code_reg  <= code_next;
            valid_reg <= valid_next;
            held_reg  <= held_next;
        end
    end

`ifdef KEYPAD_REPEAT_EN
    assign rep_inc = rep_reg + 1'b1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rep_reg <= '0;
        end else begin
            rep_reg <= rep_next;
        end
    end
`endif

    // All decisions are taken on the one sample per slot, in its last cycle.
    always_comb begin
        state_next = state_reg;
        col_next   = col_reg;
        row_next   = row_reg;
        pat_next   = pat_reg;
        deb_next   = deb_reg;
        code_next  = code_reg;
        valid_next = 1'b0;
        held_next  = held_reg;
`ifdef KEYPAD_REPEAT_EN
        rep_next   = rep_reg;
`endif
        if (slot_end) begin
            case (state_reg)
                ST_SCAN: begin
                    if (row_sync == KEY_NONE) begin
                        col_next = col_reg + 2'd1;
                    end else begin
                        pat_next   = row_sync;
                        row_next   = lowest_low(row_sync);
                        deb_next   = DEB_W'(1);
                        state_next = ST_DEBOUNCE;
                    end
                end
                ST_DEBOUNCE: begin
                    if (row_sync == pat_reg) begin
                        deb_next = deb_inc;
                        if (deb_inc >= DEB_TARGET) begin
                            state_next = ST_PRESSED;
                            code_next  = {row_reg, col_reg};
                            valid_next = 1'b1;
                            held_next  = 1'b1;
`ifdef KEYPAD_REPEAT_EN
                            rep_next   = '0;
`endif
                        end
                    end else begin
                        state_next = ST_SCAN;
                    end
                end
                ST_PRESSED: begin
                    if (row_released) begin
                        deb_next   = DEB_W'(1);
                        state_next = ST_RELEASE;
                    end else begin
`ifdef KEYPAD_REPEAT_EN
                        // After the first repeat, reload so every later repeat is REPEAT_RATE apart.
                        if (rep_inc == REP_LAST) begin
                            valid_next = 1'b1;
                            rep_next   = REP_RELOAD;
                        end else begin
                            rep_next   = rep_inc;
                        end
`endif
                    end
                end
                ST_RELEASE: begin
                    if (!row_released) begin
                        state_next = ST_PRESSED;
`ifdef KEYPAD_REPEAT_EN
                        rep_next   = '0;
`endif
                    end else begin
                        deb_next = deb_inc;
                        if (deb_inc >= DEB_TARGET) begin
                            held_next  = 1'b0;
                            col_next   = col_reg + 2'd1;
                            deb_next   = '0;
                            state_next = ST_SCAN;
                        end
                    end
                end
                default: state_next = ST_SCAN;
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a behavioural 4x4 key matrix.
// Expected strobe counts follow KEYPAD_REPEAT_EN when it is defined for the build.
module tb_keypad_scanner;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] row_n;
    logic [3:0] col_n;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;
    logic [15:0] keys = '0;   // bit r*4+c = key at row r, column c pressed

    int n_cmp = 0;
    int n_bad = 0;
    int valid_cnt = 0;

    always #5 clk = ~clk;

    keypad_scanner #(
        .SCAN_DIV     (4),
        .DEBOUNCE_CNT (3),
        .REPEAT_DLY   (5),
        .REPEAT_RATE  (2)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .row_n     (row_n),
        .col_n     (col_n),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    // Pressed key shorts its row to its column; rows idle high via pull-ups.
    always_comb begin
        row_n = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys[4'(r * 4 + c)] && !col_n[2'(c)]) begin
                    row_n[2'(r)] = 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (key_valid === 1'b1) valid_cnt++;
    end

    task automatic check_eq(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 reset_n = 1'b0;
        keys = '0;
        #1;
        check_eq("rst_col_n", int'(col_n), int'(4'b1110));
        check_eq("rst_key_code", int'(key_code), 0);
        check_eq("rst_key_valid", int'(key_valid), 0);
        check_eq("rst_key_held", int'(key_held), 0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic wait_strobe(input string tag, input int max_cyc, output int n);
        n = 0;
        while (key_valid !== 1'b1 && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        check_eq({tag, "_strobe_seen"}, int'(key_valid), 1);
    endtask

    task automatic wait_held_low(input string tag, input int max_cyc, output int n);
        n = 0;
        while (key_held !== 1'b0 && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        check_eq({tag, "_released"}, int'(key_held), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        int n;
        logic [3:0] e;

        // 1: idle scan, column moves every 4 clocks, no strobe
        do_reset();
        base = valid_cnt;
        for (int i = 0; i < 16; i++) begin
            e = ~(4'b0001 << ((i / 4) % 4));
            check_eq($sformatf("t1_col_%0d", i), int'(col_n), int'(e));
            @(negedge clk);
        end
        check_eq("t1_no_strobe", valid_cnt - base, 0);

        // 2: clean press row2/col1
        do_reset();
        base = valid_cnt;
        keys[9] = 1'b1;
        wait_strobe("t2", 100, n);
        check_eq("t2_latency", n, 16);
        check_eq("t2_code", int'(key_code), int'(4'b1001));
        check_eq("t2_held", int'(key_held), 1);
        for (int i = 0; i < 3; i++) begin
            repeat (4) @(negedge clk);
            check_eq("t2_col_frozen", int'(col_n), int'(4'b1101));
        end
        keys = '0;
        repeat (4) @(negedge clk);
        check_eq("t2_held_after_rel", int'(key_held), 1);
        wait_held_low("t2", 40, n);
        check_eq("t2_release_latency", n + 4, 12);
        check_eq("t2_col_advanced", int'(col_n), int'(4'b1011));
        check_eq("t2_strobes", valid_cnt - base, 1);

        // 3: bounce on row0/col3 - press one slot, open one slot, then stable
        do_reset();
        base = valid_cnt;
        repeat (12) @(negedge clk);
        check_eq("t3_col3", int'(col_n), int'(4'b0111));
        keys[3] = 1'b1;
        repeat (4) @(negedge clk);
        keys[3] = 1'b0;
        repeat (4) @(negedge clk);
        keys[3] = 1'b1;
        wait_strobe("t3", 100, n);
        check_eq("t3_latency", n, 12);
        check_eq("t3_code", int'(key_code), int'(4'b0011));
        keys = '0;
        wait_held_low("t3", 60, n);
        check_eq("t3_strobes", valid_cnt - base, 1);

        // 4: rows 1 and 3 on col0, then a col2 key during the hold
        do_reset();
        base = valid_cnt;
        keys[4]  = 1'b1;
        keys[12] = 1'b1;
        wait_strobe("t4", 100, n);
        check_eq("t4_latency", n, 12);
        check_eq("t4_code", int'(key_code), int'(4'b0100));
        keys[2] = 1'b1;
        repeat (8) @(negedge clk);
        check_eq("t4_code_kept", int'(key_code), int'(4'b0100));
        check_eq("t4_col_frozen", int'(col_n), int'(4'b1110));
        check_eq("t4_strobes_hold", valid_cnt - base, 1);
        keys = '0;
        wait_held_low("t4", 60, n);
        check_eq("t4_strobes", valid_cnt - base, 1);

        // 5a: reset while debouncing
        do_reset();
        base = valid_cnt;
        keys[12] = 1'b1;
        repeat (6) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check_eq("t5a_col_n", int'(col_n), int'(4'b1110));
        check_eq("t5a_held", int'(key_held), 0);
        keys = '0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (40) @(negedge clk);
        check_eq("t5a_strobes", valid_cnt - base, 0);

        // 5b: reset while pressed, key code cleared at once
        do_reset();
        base = valid_cnt;
        keys[6] = 1'b1;
        wait_strobe("t5b", 100, n);
        check_eq("t5b_code", int'(key_code), int'(4'b0110));
        repeat (2) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check_eq("t5b_code_rst", int'(key_code), 0);
        check_eq("t5b_held_rst", int'(key_held), 0);
        check_eq("t5b_col_rst", int'(col_n), int'(4'b1110));
        keys = '0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (40) @(negedge clk);
        check_eq("t5b_strobes", valid_cnt - base, 1);
        check_eq("t5b_held_after", int'(key_held), 0);

        // 6: key held 12 slots after accept
        do_reset();
        base = valid_cnt;
        keys[0] = 1'b1;
        wait_strobe("t6", 100, n);
        check_eq("t6_code", int'(key_code), 0);
        repeat (48) @(negedge clk);
`ifdef KEYPAD_REPEAT_EN
        check_eq("t6_strobes", valid_cnt - base, 5);
`else
        check_eq("t6_strobes", valid_cnt - base, 1);
`endif
        keys = '0;
        wait_held_low("t6", 60, n);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
